// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port synchronous video RAM between the VGA
// scanout reader and the Hack CPU. One access per cycle, VGA has priority,
// read data (one cycle late) is routed back to whichever side issued the read.
// Optional build macro VRAM_ARB_FAIRNESS_EN: after STARVE_LIMIT consecutive
// VGA grants while the CPU waits, the CPU wins the next arbitration.
module vram_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vga_req,
   input  logic [ADDR_WIDTH-1:0] vga_addr,
   output logic                  vga_gnt,
   output logic                  vga_rvalid,
   output logic [15:0]           vga_rdata,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [15:0]           cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [15:0]           cpu_rdata,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_load,
   output logic [15:0]           ram_in,
   input  logic [15:0]           ram_out
);

   logic                  force_cpu;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  vga_rd_d;
   logic                  vga_rd_q;
   logic                  cpu_rd_d;
   logic                  cpu_rd_q;

`ifdef VRAM_ARB_FAIRNESS_EN
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [7:0] starve_d;
   logic [7:0] starve_q;

   // The CPU has waited long enough: it takes the next slot from VGA.
   assign force_cpu = cpu_req && (starve_q == LIMIT);

   // Count VGA wins while the CPU waits; a CPU grant or an idle CPU clears it.
   always_comb begin
      starve_d = starve_q;
      if (cpu_gnt || !cpu_req) begin
         starve_d = 8'd0;
      end else if (vga_gnt) begin
         starve_d = starve_q + 8'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= 8'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   // Strict VGA priority: the CPU is never forced ahead.
   assign force_cpu = 1'b0;

   // Keep the limit range-checked even though this build does not use it.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("vram_arbiter: STARVE_LIMIT out of range 1..255");
   end
`endif

   // Grant decision from this cycle's requests; no grants while in reset.
   always_comb begin
      vga_gnt = 1'b0;
      cpu_gnt = 1'b0;
      if (!rst_n) begin
         vga_gnt = 1'b0;
         cpu_gnt = 1'b0;
      end else if (force_cpu) begin
         cpu_gnt = 1'b1;
      end else if (vga_req) begin
         vga_gnt = 1'b1;
      end else begin
         cpu_gnt = cpu_req;
      end
   end

   // Winner's address drives the RAM; when idle the last address is held.
   always_comb begin
      addr_d = addr_q;
      if (vga_gnt) begin
         addr_d = vga_addr;
      end else if (cpu_gnt) begin
         addr_d = cpu_addr;
      end else begin
         addr_d = addr_q;
      end
   end

   assign ram_address = addr_d;
   assign ram_load    = cpu_gnt & cpu_we;
   assign ram_in      = cpu_gnt ? cpu_wdata : 16'h0000;

   // A read granted now returns data next cycle; remember who asked.
   always_comb begin
      vga_rd_d = vga_gnt;
      cpu_rd_d = cpu_gnt & ~cpu_we;
   end

   // Held address and read-owner pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         vga_rd_q <= 1'b0;
         cpu_rd_q <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         vga_rd_q <= vga_rd_d;
         cpu_rd_q <= cpu_rd_d;
      end
   end

   assign vga_rvalid = vga_rd_q;
   assign cpu_rvalid = cpu_rd_q;
   assign vga_rdata  = ram_out;
   assign cpu_rdata  = ram_out;

endmodule
